// File: rtl/pseudo_ana_stk_n.sv
// Digital-to-pseudo-analog stick: NAXIS direction pairs become W-bit axis values,
// stepped once per VTICK rising edge by a serial per-axis FSM and published together.
module pseudo_ana_stk_n #(
  parameter int NAXIS        = 2,
  parameter int W            = 8,
  parameter int DELT_MIN     = 4,
  parameter int DELT_MAX     = 15,
  parameter int ACCEL_FRAMES = 4,
  parameter int LIM          = 120,
  parameter int RET          = 15
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               VTICK,
  input  logic               ENABLE,
  input  logic [NAXIS-1:0]   INC,
  input  logic [NAXIS-1:0]   DEC,
  output logic [NAXIS*W-1:0] AXIS,
  output logic               VALID
);

  localparam int PW     = W + 2;
  localparam int IW     = (NAXIS > 1) ? $clog2(NAXIS) : 1;
  localparam int CW     = $clog2(ACCEL_FRAMES + 1);
  localparam int CENTRE = 2**(W-1) - 1;

  localparam logic signed [PW-1:0] LIM_P  = PW'(LIM);
  localparam logic signed [PW-1:0] RET_P  = PW'(RET);
  localparam logic signed [PW-1:0] DMIN_P = PW'(DELT_MIN);
  localparam logic signed [PW-1:0] DMAX_P = PW'(DELT_MAX);
  localparam logic [1:0] DIR_NONE = 2'b00;

  typedef enum logic [1:0] {S_IDLE, S_UPD, S_PUB} state_t;

  state_t                 state_q, state_d;
  logic                   vtick_q;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NAXIS-1:0]       inc_q, inc_d, dec_q, dec_d;
  logic signed [PW-1:0]   pos_q  [NAXIS];
  logic signed [PW-1:0]   pos_d  [NAXIS];
  logic signed [PW-1:0]   step_q [NAXIS];
  logic signed [PW-1:0]   step_d [NAXIS];
  logic [CW-1:0]          cnt_q  [NAXIS];
  logic [CW-1:0]          cnt_d  [NAXIS];
  logic [1:0]             dir_q  [NAXIS];
  logic [1:0]             dir_d  [NAXIS];
  logic [NAXIS*W-1:0]     axis_q, axis_d;
  logic                   valid_q, valid_d;

  logic                   tick_edge;
  logic                   plus_v, minus_v;
  logic [1:0]             dir_v;
  logic signed [PW-1:0]   p_v, s_v;
  logic [CW-1:0]          c_v;

  assign tick_edge = VTICK & ~vtick_q;
  assign AXIS      = axis_q;
  assign VALID     = valid_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      vtick_q <= 1'b0;
      idx_q   <= '0;
      inc_q   <= '0;
      dec_q   <= '0;
      axis_q  <= {NAXIS{W'(CENTRE)}};
      valid_q <= 1'b0;
      for (int i = 0; i < NAXIS; i++) begin
        pos_q[i]  <= '0;
        step_q[i] <= DMIN_P;
        cnt_q[i]  <= '0;
        dir_q[i]  <= DIR_NONE;
      end
    end else begin
      state_q <= state_d;
      vtick_q <= VTICK;
      idx_q   <= idx_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      axis_q  <= axis_d;
      valid_q <= valid_d;
      pos_q   <= pos_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    inc_d   = inc_q;
    dec_d   = dec_q;
    axis_d  = axis_q;
    valid_d = 1'b0;
    pos_d   = pos_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    plus_v  = inc_q[idx_q] & ~dec_q[idx_q];
    minus_v = dec_q[idx_q] & ~inc_q[idx_q];
    dir_v   = {minus_v, plus_v};
    p_v     = pos_q[idx_q];
    s_v     = step_q[idx_q];
    c_v     = cnt_q[idx_q];

    unique case (state_q)
      S_IDLE: begin
        if (tick_edge && ENABLE) begin
          inc_d   = INC;
          dec_d   = DEC;
          idx_d   = '0;
          state_d = S_UPD;
        end
      end
      S_UPD: begin
        if (plus_v || minus_v) begin
          // A fresh direction (including coming out of release) restarts acceleration.
          if (dir_v != dir_q[idx_q]) begin
            s_v = DMIN_P;
            c_v = '0;
          end
          p_v = plus_v ? (p_v + s_v) : (p_v - s_v);
          c_v = c_v + CW'(1);
          if (c_v == CW'(ACCEL_FRAMES)) begin
            c_v = '0;
            if (s_v < DMAX_P) s_v = s_v + PW'(1);
          end
        end else begin
          if (p_v > RET_P)       p_v = p_v - RET_P;
          else if (p_v < -RET_P) p_v = p_v + RET_P;
          else                   p_v = '0;
          s_v = DMIN_P;
          c_v = '0;
        end
        if (p_v > LIM_P)       p_v = LIM_P;
        else if (p_v < -LIM_P) p_v = -LIM_P;
        pos_d[idx_q]  = p_v;
        step_d[idx_q] = s_v;
        cnt_d[idx_q]  = c_v;
        dir_d[idx_q]  = dir_v;
        if (idx_q == IW'(NAXIS - 1)) state_d = S_PUB;
        else                         idx_d   = idx_q + IW'(1);
      end
      S_PUB: begin
        for (int i = 0; i < NAXIS; i++)
          axis_d[i*W +: W] = pos_q[i][W-1:0] + W'(CENTRE);
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pseudo_ana_stk_n.sv
// Scoreboard bench for pseudo_ana_stk_n: stimulus pushes expected AXIS and publish cycle,
// a negedge monitor pops on every VALID. A NAXIS=4 instance covers dropped edges and ENABLE.
module tb_pseudo_ana_stk_n;

  typedef struct {
    logic [15:0] axis;
    int          cyc;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        VTICK = 1'b0;
  logic        ENABLE = 1'b1;
  logic [1:0]  INC = '0;
  logic [1:0]  DEC = '0;
  logic [15:0] AXIS;
  logic        VALID;
  logic [31:0] AXIS4;
  logic        VALID4;

  exp_t sb[$];
  int   ntests = 0;
  int   nfail  = 0;
  int   cyc    = 0;
  int   v4_cnt = 0;
  int   mp[2], md[2], mc[2], ml[2];
  logic [15:0] last_axis;

  pseudo_ana_stk_n dut (
    .CLK(CLK), .RESET_N(RESET_N), .VTICK(VTICK), .ENABLE(ENABLE),
    .INC(INC), .DEC(DEC), .AXIS(AXIS), .VALID(VALID)
  );

  pseudo_ana_stk_n #(.NAXIS(4)) dut4 (
    .CLK(CLK), .RESET_N(RESET_N), .VTICK(VTICK), .ENABLE(ENABLE),
    .INC({2'b00, INC}), .DEC({2'b00, DEC}), .AXIS(AXIS4), .VALID(VALID4)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (VALID4) v4_cnt <= v4_cnt + 1;
  end

  always @(negedge CLK) begin
    if (VALID) begin
      ntests++;
      if (sb.size() == 0) begin
        nfail++;
        $display("FAIL unexpected_valid: VALID=1 at cycle %0d, required no pulse", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (AXIS !== e.axis) begin
          nfail++;
          $display("FAIL axis_value: got %0d/%0d, required %0d/%0d",
                   AXIS[15:8], AXIS[7:0], e.axis[15:8], e.axis[7:0]);
        end
        ntests++;
        if (cyc != e.cyc) begin
          nfail++;
          $display("FAIL valid_latency: pulse at cycle %0d, required %0d", cyc, e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    ntests++;
    if (got !== req) begin
      nfail++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < 2; a++) begin
      mp[a] = 0; md[a] = 4; mc[a] = 0; ml[a] = 0;
    end
  endtask

  task automatic model_axis(input int a, input bit i, input bit d);
    int dir;
    dir = (i && !d) ? 1 : ((d && !i) ? -1 : 0);
    if (dir != 0) begin
      if (dir != ml[a]) begin md[a] = 4; mc[a] = 0; end
      mp[a] = mp[a] + dir * md[a];
      mc[a] = mc[a] + 1;
      if (mc[a] == 4) begin
        mc[a] = 0;
        if (md[a] < 15) md[a] = md[a] + 1;
      end
    end else begin
      if (mp[a] > 15)       mp[a] = mp[a] - 15;
      else if (mp[a] < -15) mp[a] = mp[a] + 15;
      else                  mp[a] = 0;
      md[a] = 4; mc[a] = 0;
    end
    ml[a] = dir;
    if (mp[a] > 120)  mp[a] = 120;
    if (mp[a] < -120) mp[a] = -120;
  endtask

  // One frame: rising VTICK with the given directions; hand_ax0 >= 0 overrides the model for axis 0.
  task automatic do_frame(input logic [1:0] inc, input logic [1:0] dec, input int hand_ax0);
    exp_t e;
    int   a0, a1;
    model_axis(0, inc[0], dec[0]);
    model_axis(1, inc[1], dec[1]);
    a0 = (hand_ax0 >= 0) ? hand_ax0 : (mp[0] + 127);
    a1 = mp[1] + 127;
    @(negedge CLK);
    INC = inc; DEC = dec; VTICK = 1'b1;
    e.axis = {a1[7:0], a0[7:0]};
    e.cyc  = cyc + 4;
    sb.push_back(e);
    last_axis = e.axis;
    @(negedge CLK);
    VTICK = 1'b0;
    INC = ~inc; DEC = ~dec;
    repeat (6) @(negedge CLK);
    INC = '0; DEC = '0;
  endtask

  task automatic frames(input int n, input logic [1:0] inc, input logic [1:0] dec);
    for (int k = 0; k < n; k++) do_frame(inc, dec, -1);
  endtask

  initial begin
    int v4_before;
    logic [31:0] a4_before;
    model_reset();
    last_axis = 16'h7F7F;
    repeat (3) @(negedge CLK);
    check("reset_axis", {16'h0, AXIS}, 32'h7F7F);
    check("reset_valid", {31'h0, VALID}, 32'h0);
    RESET_N = 1'b1;
    repeat (10) @(negedge CLK);
    check("idle_axis", {16'h0, AXIS}, 32'h7F7F);
    check("idle_axis4", AXIS4, 32'h7F7F7F7F);

    // Acceleration profile from rest, then saturation at the limit
    do_frame(2'b01, 2'b00, 131);
    do_frame(2'b01, 2'b00, 135);
    do_frame(2'b01, 2'b00, 139);
    do_frame(2'b01, 2'b00, 143);
    do_frame(2'b01, 2'b00, 148);
    frames(24, 2'b01, 2'b00);
    do_frame(2'b01, 2'b00, 247);

    // Reversal restarts at the minimum step and runs to the negative limit
    do_frame(2'b00, 2'b01, 243);
    frames(32, 2'b00, 2'b01);
    do_frame(2'b00, 2'b01, 7);

    // Return to centre, rebuild P=21, then release and both-held release
    frames(8, 2'b00, 2'b00);
    check("centre_model", mp[0], 0);
    frames(4, 2'b01, 2'b00);
    do_frame(2'b01, 2'b00, 148);
    do_frame(2'b00, 2'b00, 133);
    do_frame(2'b00, 2'b00, 127);
    do_frame(2'b00, 2'b00, 127);
    frames(4, 2'b01, 2'b00);
    do_frame(2'b01, 2'b00, 148);
    do_frame(2'b01, 2'b01, 133);
    do_frame(2'b01, 2'b01, 127);
    do_frame(2'b01, 2'b01, 127);

    // Second edge while busy is dropped (both widths)
    v4_before = v4_cnt;
    begin
      exp_t e;
      model_axis(0, 1'b1, 1'b0);
      model_axis(1, 1'b0, 1'b0);
      @(negedge CLK);
      INC = 2'b01; DEC = 2'b00; VTICK = 1'b1;
      e.axis = {8'd127, 8'd131};
      e.cyc  = cyc + 4;
      sb.push_back(e);
      last_axis = e.axis;
      @(negedge CLK); VTICK = 1'b0;
      @(negedge CLK); VTICK = 1'b1;
      @(negedge CLK); VTICK = 1'b0;
      repeat (10) @(negedge CLK);
    end
    check("double_edge_valid4", v4_cnt - v4_before, 1);
    check("double_edge_axis4", AXIS4, 32'h7F7F7F83);

    // ENABLE low: edges ignored, nothing published
    v4_before = v4_cnt;
    a4_before = AXIS4;
    ENABLE = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK); INC = 2'b11 ^ 2'b10; VTICK = 1'b1;
      @(negedge CLK); VTICK = 1'b0;
      repeat (6) @(negedge CLK);
    end
    INC = '0;
    ENABLE = 1'b1;
    check("disabled_axis", {16'h0, AXIS}, {16'h0, last_axis});
    check("disabled_axis4", AXIS4, a4_before);
    check("disabled_valid4", v4_cnt - v4_before, 0);

    // Reset during UPD after three held frames
    do_frame(2'b01, 2'b00, 135);
    do_frame(2'b01, 2'b00, 139);
    do_frame(2'b01, 2'b00, 143);
    check("pre_reset_axis", {16'h0, AXIS}, 32'h7F8F);
    @(negedge CLK);
    INC = 2'b01; VTICK = 1'b1;
    @(negedge CLK);
    VTICK = 1'b0;
    RESET_N = 1'b0;
    #1;
    check("midupd_reset_axis", {16'h0, AXIS}, 32'h7F7F);
    check("midupd_reset_axis4", AXIS4, 32'h7F7F7F7F);
    check("midupd_pending", sb.size(), 0);
    @(negedge CLK);
    RESET_N = 1'b1;
    INC = '0;
    model_reset();
    repeat (8) @(negedge CLK);
    check("post_reset_axis", {16'h0, AXIS}, 32'h7F7F);
    do_frame(2'b01, 2'b00, 131);

    begin
      int guard = 0;
      while (sb.size() != 0 && guard < 20) begin
        @(negedge CLK);
        guard++;
      end
      ntests++;
      if (sb.size() != 0) begin
        nfail++;
        $display("FAIL drain_timeout: %0d expected publishes outstanding, required 0", sb.size());
      end
    end
    repeat (4) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
